// File: rtl/SB_codex_pkg.sv
// Shared sideband codex types: message opcodes, TX arbiter FSM states and defaults.
// Pure declarations, no logic.
// Imported by the sideband TX arbiter and its round-robin picker.
package SB_codex_pkg;

  // Sideband message opcodes; all-zero is the idle/no-message encoding
  typedef enum logic [4:0] {
    SB_MSG_NONE            = 5'd0,
    SBINIT_OUT_OF_RESET    = 5'd1,
    SBINIT_DONE_REQ        = 5'd2,
    SBINIT_DONE_RESP       = 5'd3,
    MBINIT_PARAM_CFG_REQ   = 5'd4,
    MBINIT_PARAM_CFG_RESP  = 5'd5,
    MBTRAIN_VALVREF_REQ    = 5'd6,
    MBTRAIN_VALVREF_RESP   = 5'd7,
    ACTIVE_LINKMGMT_REQ    = 5'd8,
    ACTIVE_LINKMGMT_RESP   = 5'd9
  } SB_msg_t;

  // TX arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } sb_arb_state_t;

  localparam int SB_ARB_NUM_REQ_DEF     = 4;
  localparam int SB_ARB_WDOG_CYCLES_DEF = 1024;

endpackage

// File: rtl/sb_tx_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request at or above ptr, wrapping modulo NUM_REQ.
// Purely combinational, zero latency.
// No flow control; any=0 when no request is set (grant and idx are then 0).
module rr_priority_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  int          k;
  logic [IW-1:0] kk;

  // Scan NUM_REQ positions starting at ptr; the first hit wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    kk  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k  = (int'(ptr) + i) % NUM_REQ;
      kk = IW'(k);
      if (!any && req[kk]) begin
        any     = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter for the sideband TX message channel (IDLE -> SEND -> DONE).
// Latency: request in IDLE -> valid next cycle; flag sampled -> ack next cycle; 3-cycle minimum period.
// Holds message/valid until SB_TX_msg_sendNextFlag_i; optional watchdog via SB_TX_ARB_WDOG_EN.
module sb_tx_arbiter
  import SB_codex_pkg::*;
#(
  parameter int NUM_REQ     = SB_ARB_NUM_REQ_DEF,
  parameter int WDOG_CYCLES = SB_ARB_WDOG_CYCLES_DEF
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  SB_msg_t                    req_msg_i [NUM_REQ],
  input  logic [63:0]                req_data_i [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic [NUM_REQ-1:0]         req_err_o,
  output SB_msg_t                    SB_TX_msg_o,
  output logic [63:0]                SB_TX_dataBus_o,
  output logic                       SB_TX_msg_valid_o,
  input  logic                       SB_TX_msg_sendNextFlag_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       busy_o
);

  localparam int IW = $clog2(NUM_REQ);

  // Reject out-of-range configurations at elaboration
  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("sb_tx_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES >= 1");
  end

  sb_arb_state_t      state_q, state_d;
  logic [IW-1:0]      rr_ptr_q;
  logic [IW-1:0]      gidx_q;
  logic [NUM_REQ-1:0] goh_q;
  SB_msg_t            msg_q;
  logic [63:0]        data_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               grant_now;
  logic               wdog_hit;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign grant_now = (state_q == IDLE) && pick_any;

`ifdef SB_TX_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wdog_cnt_q;
  logic          err_q;

  // Abort on the SEND cycle that would bring the no-flag count up to WDOG_CYCLES
  assign wdog_hit = (wdog_cnt_q == CW'(WDOG_CYCLES - 1));

  // Watchdog counter and abort flag; a flag in the limit cycle still counts as success
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      wdog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (grant_now) begin
      wdog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (state_q == SEND && !SB_TX_msg_sendNextFlag_i) begin
      wdog_cnt_q <= wdog_cnt_q + CW'(1);
      if (wdog_hit) err_q <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; requester inputs only matter in IDLE, the flag only in SEND
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = SEND;
      SEND:    if (SB_TX_msg_sendNextFlag_i || wdog_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner's message/data and advance the round-robin pointer on a grant
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      goh_q    <= '0;
      msg_q    <= SB_MSG_NONE;
      data_q   <= '0;
    end else if (grant_now) begin
      rr_ptr_q <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
      gidx_q   <= pick_idx;
      goh_q    <= pick_gnt;
      msg_q    <= req_msg_i[pick_idx];
      data_q   <= req_data_i[pick_idx];
    end
  end

  // Outputs decoded from state; ack/err are the registered one-hot grant gated by DONE
  always_comb begin
    SB_TX_msg_o       = msg_q;
    SB_TX_dataBus_o   = data_q;
    grant_idx_o       = gidx_q;
    SB_TX_msg_valid_o = (state_q == SEND);
    busy_o            = (state_q != IDLE);
    req_ack_o         = (state_q == DONE) ? goh_q : '0;
`ifdef SB_TX_ARB_WDOG_EN
    req_err_o         = (state_q == DONE && err_q) ? goh_q : '0;
`else
    req_err_o         = '0;
`endif
  end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed self-checking bench for sb_tx_arbiter (NUM_REQ=4).
// Inputs change and outputs are checked just after the falling clock edge.
// Watchdog expectations follow whether SB_TX_ARB_WDOG_EN is defined.
module tb_sb_tx_arbiter;
  import SB_codex_pkg::*;

`ifdef SB_TX_ARB_WDOG_EN
  localparam int TB_WDOG = 8;
`else
  localparam int TB_WDOG = 1024;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  SB_msg_t     req_msg [4];
  logic [63:0] req_data [4];
  logic [3:0]  req_ack;
  logic [3:0]  req_err;
  SB_msg_t     tx_msg;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_flag;
  logic [1:0]  grant_idx;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  sb_tx_arbiter #(.NUM_REQ(4), .WDOG_CYCLES(TB_WDOG)) dut (
    .clk_100MHz               (clk),
    .reset                    (reset),
    .req_valid_i              (req_valid),
    .req_msg_i                (req_msg),
    .req_data_i               (req_data),
    .req_ack_o                (req_ack),
    .req_err_o                (req_err),
    .SB_TX_msg_o              (tx_msg),
    .SB_TX_dataBus_o          (tx_data),
    .SB_TX_msg_valid_o        (tx_valid),
    .SB_TX_msg_sendNextFlag_i (tx_flag),
    .grant_idx_o              (grant_idx),
    .busy_o                   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  int          cnt;
  int          ack_seen;
  logic [3:0]  exp_oh;

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    tx_flag   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_msg[i]  = SB_msg_t'(i + 1);
      req_data[i] = {32'hD00D_0000 + 32'(i), 32'hCAFE_F00D};
    end
    cyc();
    cyc();

    // Reset state
    check("rst_valid", 64'(tx_valid), 64'd0);
    check("rst_msg",   64'(tx_msg),   64'd0);
    check("rst_data",  tx_data,       64'd0);
    check("rst_ack",   64'(req_ack),  64'd0);
    check("rst_err",   64'(req_err),  64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_busy",  64'(busy),     64'd0);
    reset = 1'b1;
    cyc();
    check("idle_busy", 64'(busy), 64'd0);

    // Single request from requester 2, flag on third SEND cycle
    req_valid = 4'b0100;
    cyc();
    check("t1_valid", 64'(tx_valid),  64'd1);
    check("t1_msg",   64'(tx_msg),    64'(SBINIT_DONE_RESP));
    check("t1_data",  tx_data,        {32'hD00D_0002, 32'hCAFE_F00D});
    check("t1_grant", 64'(grant_idx), 64'd2);
    check("t1_busy",  64'(busy),      64'd1);
    check("t1_noack", 64'(req_ack),   64'd0);
    cyc();
    check("t1_valid2", 64'(tx_valid), 64'd1);
    cyc();
    check("t1_valid3", 64'(tx_valid), 64'd1);
    tx_flag = 1'b1;
    cyc();
    check("t1_done_valid", 64'(tx_valid), 64'd0);
    check("t1_ack",        64'(req_ack),  64'b0100);
    check("t1_err",        64'(req_err),  64'd0);
    check("t1_done_busy",  64'(busy),     64'd1);
    tx_flag   = 1'b0;
    req_valid = '0;
    cyc();
    check("t1_idle_busy", 64'(busy),    64'd0);
    check("t1_idle_ack",  64'(req_ack), 64'd0);

    // Fairness: all four held, flag always high -> 0,1,2,3,0 every 3 cycles
    do_reset();
    req_valid = 4'hF;
    tx_flag   = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'b0001 << (g % 4);
      cyc();
      check("t2_grant", 64'(grant_idx), 64'(g % 4));
      check("t2_valid", 64'(tx_valid),  64'd1);
      check("t2_data",  tx_data,        {32'hD00D_0000 + 32'(g % 4), 32'hCAFE_F00D});
      cyc();
      check("t2_ack",   64'(req_ack),   64'(exp_oh));
      cyc();
      check("t2_idle",  64'(busy),      64'd0);
    end
    req_valid = '0;
    tx_flag   = 1'b0;
    cyc();

    // Pointer at 2 with requests 0 and 3 -> 3 then wrap to 0
    do_reset();
    req_valid = 4'b0010;
    tx_flag   = 1'b1;
    cyc();
    check("t3_grant1", 64'(grant_idx), 64'd1);
    cyc();
    req_valid = 4'b1001;
    cyc();
    cyc();
    check("t3_grant3", 64'(grant_idx), 64'd3);
    cyc();
    check("t3_ack3",   64'(req_ack),   64'b1000);
    cyc();
    cyc();
    check("t3_grant0", 64'(grant_idx), 64'd0);
    cyc();
    check("t3_ack0",   64'(req_ack),   64'b0001);
    req_valid = '0;
    tx_flag   = 1'b0;
    cyc();

    // Asynchronous reset in the middle of SEND
    req_valid = 4'b0100;
    cyc();
    check("t4_send", 64'(tx_valid), 64'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t4_valid", 64'(tx_valid),  64'd0);
    check("t4_msg",   64'(tx_msg),    64'd0);
    check("t4_data",  tx_data,        64'd0);
    check("t4_grant", 64'(grant_idx), 64'd0);
    check("t4_busy",  64'(busy),      64'd0);
    check("t4_ack",   64'(req_ack),   64'd0);
    cyc();
    req_valid = '0;
    reset     = 1'b1;
    ack_seen  = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (req_ack != '0) ack_seen++;
    end
    check("t4_noack",   64'(ack_seen), 64'd0);
    check("t4_idle",    64'(busy),     64'd0);
    req_valid = 4'b1001;
    cyc();
    check("t4_ptr_rst", 64'(grant_idx), 64'd0);
    tx_flag = 1'b1;
    cyc();
    req_valid = '0;
    tx_flag   = 1'b0;
    cyc();

    // Flag never returned: watchdog abort or indefinite wait
    req_valid = 4'b0001;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (tx_valid) cnt++;
      else break;
    end
`ifdef SB_TX_ARB_WDOG_EN
    check("t5_wdog_len", 64'(cnt),     64'd8);
    check("t5_wdog_ack", 64'(req_ack), 64'b0001);
    check("t5_wdog_err", 64'(req_err), 64'b0001);
    req_valid = '0;
    cyc();
`else
    check("t5_hold_len", 64'(cnt),     64'd150);
    check("t5_hold_err", 64'(req_err), 64'd0);
    tx_flag = 1'b1;
    cyc();
    check("t5_late_ack", 64'(req_ack), 64'b0001);
    check("t5_late_err", 64'(req_err), 64'd0);
    tx_flag   = 1'b0;
    req_valid = '0;
    cyc();
`endif
    check("t5_idle", 64'(busy), 64'd0);

    // Flag pulsed in IDLE must not complete a later transfer
    tx_flag = 1'b1;
    cyc();
    check("t6_idle_ack", 64'(req_ack), 64'd0);
    tx_flag   = 1'b0;
    req_valid = 4'b0010;
    cyc();
    check("t6_send",   64'(tx_valid), 64'd1);
    cyc();
    check("t6_wait1",  64'(tx_valid), 64'd1);
    cyc();
    check("t6_wait2",  64'(tx_valid), 64'd1);
    check("t6_noack",  64'(req_ack),  64'd0);
    tx_flag = 1'b1;
    cyc();
    check("t6_ack",    64'(req_ack),  64'b0010);
    tx_flag   = 1'b0;
    req_valid = '0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_tx_arbiter.md
# sb_tx_arbiter

Round-robin arbiter sharing the single sideband TX message channel between up to NUM_REQ LTSM state blocks (RESET, SBINIT, MBINIT, MBTRAIN, ACTIVE, ...). Each requester presents an `SB_msg_t` plus a 64-bit data word and holds a valid until acknowledged. The arbiter latches the winning message, drives the SB TX message port until the SB transmitter accepts it, then returns a one-cycle acknowledge. It sits between the LTSM state modules and the sideband TX serializer, in the 100 MHz sideband clock domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WDOG_CYCLES, 1024, SEND-state watchdog limit in clk_100MHz cycles (used only with watchdog compiled in)

- clk_100MHz  input  1  sideband clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- req_valid_i  input  NUM_REQ  per-requester request; held high until matching req_ack_o
- req_msg_i  input  NUM_REQ x SB_msg_t  per-requester message opcode
- req_data_i  input  NUM_REQ x 64  per-requester data word
- req_ack_o  output  NUM_REQ  one-hot, one-cycle acknowledge to the served requester
- req_err_o  output  NUM_REQ  one-hot, one-cycle watchdog-abort flag, coincident with req_ack_o
- SB_TX_msg_o  output  SB_msg_t  message to SB transmitter
- SB_TX_dataBus_o  output  64  data to SB transmitter
- SB_TX_msg_valid_o  output  1  message valid
- SB_TX_msg_sendNextFlag_i  input  1  transmitter has accepted the current message
- grant_idx_o  output  $clog2(NUM_REQ)  index of the current or last granted requester
- busy_o  output  1  high in SEND and DONE

## Operation
- FSM states are IDLE, SEND and DONE.
- **IDLE:**
  - If any req_valid_i is high, pick winner g as the first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - Register req_msg_i[g] into SB_TX_msg_o and req_data_i[g] into SB_TX_dataBus_o. Set grant_idx_o=g.
  - Set rr_ptr=(g+1) mod NUM_REQ and go to SEND.
  - If no req_valid_i is high, stay in IDLE.
- **SEND:**
  - SB_TX_msg_valid_o is high. Message and data are frozen.
  - When SB_TX_msg_sendNextFlag_i=1 is sampled, go to DONE.
  - Requester inputs are ignored. Dropping req_valid_i mid-SEND does not cancel the transfer.
- **DONE:**
  - req_ack_o[grant_idx] is high for this cycle only. SB_TX_msg_valid_o is low.
  - No arbitration in this state, so the acked requester can drop its valid. Then go to IDLE.
- sendNextFlag is ignored outside SEND.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - All outputs are 0: SB_TX_msg_o is all-zero encoding, data 0, valid 0, ack 0, err 0, grant_idx 0, busy 0.
- Reset asserted mid-SEND aborts immediately. No ack is issued, and the requester must re-request.

## Timing
- Request seen in IDLE at cycle 0 → SB_TX_msg_valid_o high from cycle 1.
- Flag sampled high at cycle k (k≥1) → valid low and ack high at k+1, IDLE at k+2.
- The earliest next valid is at k+3.
- Minimum message period is 3 cycles, which occurs when the flag is high in the first SEND cycle.
- Simultaneous requests: exactly one grant per IDLE evaluation. Fairness: with all NUM_REQ valid continuously, grants rotate 0,1,2,…,NUM_REQ-1,0.
- A new request arriving during SEND/DONE is evaluated in the next IDLE.

## Configuration
- Macro: `SB_TX_ARB_WDOG_EN`.
- **Defined:**
  - A $clog2(WDOG_CYCLES+1)-bit counter clears on entering SEND and increments each SEND cycle without the flag.
  - When the counter reaches WDOG_CYCLES, the transfer is aborted: valid drops, state goes to DONE, and req_err_o[g] pulses together with req_ack_o[g].
  - A flag and a limit hit in the same cycle count as success: no err.
- **Undefined:** SEND waits indefinitely, and req_err_o is tied to 0. WDOG_CYCLES is unused.

## Structure
- Add to SB_codex_pkg:
  - `sb_arb_state_t` enum (IDLE, SEND, DONE).
  - Default constants for NUM_REQ and WDOG_CYCLES.
- `SB_msg_t` remains in SB_codex_pkg.
- One sub-module, `rr_priority_picker`: combinational, takes the request vector and rr_ptr, and produces a one-hot grant and its index.
- The FSM, output registers and watchdog live in sb_tx_arbiter.

## Test plan
- Single request, req 2 valid at cycle 0, flag high at cycle 3 → valid high cycles 1–3 with req 2 msg/data, req_ack_o=4'b0100 at cycle 4, busy low at cycle 5.
- All four requests held continuously, flag returned each first SEND cycle → grant order 0,1,2,3,0, one message every 3 cycles, each ack one-hot.
- rr_ptr=2 with reqs 0 and 3 valid → grant 3, then 0. Verify rr_ptr wraps 3→0.
- Reset driven low mid-SEND → all outputs 0 within the same cycle (async), FSM is IDLE after release, no ack.
- With SB_TX_ARB_WDOG_EN defined and WDOG_CYCLES=8, flag never asserted → valid drops after 8 SEND cycles, req_ack_o and req_err_o pulse together. Without the macro, valid stays high for 100+ cycles.
- Flag pulsed while IDLE, then a request arrives → flag ignored, SEND waits for a fresh flag.
